cacheline_burst_adaptor: RTL and testbench
==========================================

CACHELINE_BURST_ADAPTOR -- requirements
Module: cacheline_burst_adaptor

Interface
REQ-001 SHALL have parameter BEATS, default 4: beats per cache line.
REQ-002 SHALL have parameter BEAT_W, default 64: memory beat width in bits; line width is BEATS*BEAT_W (256).
REQ-003 SHALL have parameter TIMEOUT, default 256: cycles allowed per beat before abort; used only under REQ-029.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port read_i, input, 1: cache line-fill request, level, held until resp_o.
REQ-007 SHALL have port write_i, input, 1: cache write-back request, level, held until resp_o.
REQ-008 SHALL have port address_i, input, 32: line address from cache.
REQ-009 SHALL have port line_i, input, 256: write-back line.
REQ-010 SHALL have port line_o, output, 256: filled line; valid while resp_o=1, held until next fill completes.
REQ-011 SHALL have port resp_o, output, 1: one-cycle completion pulse to cache.
REQ-012 SHALL have port address_o, output, 32: memory address, {latched address_i[31:5], 5'b0}.
REQ-013 SHALL have port read_o / write_o, output, 1 each: memory burst commands.
REQ-014 SHALL have port burst_o, output, 64: write beat; burst_i, input, 64: read beat.
REQ-015 SHALL have port resp_i, input, 1: memory beat strobe, one beat per high cycle.
REQ-016 SHALL have port err_o, output, 1: sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, RD_BURST, WR_BURST, DONE.
REQ-018 IDLE: write_i=1 -> WR_BURST (write wins if both high); else read_i=1 -> RD_BURST; address_i and line_i latched on that edge.
REQ-019 read_o SHALL be 1 exactly in RD_BURST; write_o exactly in WR_BURST; address_o stable throughout a burst.
REQ-020 RD_BURST: each cycle with resp_i=1 SHALL store burst_i into line bits [64k+63:64k], k = 2-bit beat counter, then increment k.
REQ-021 WR_BURST: burst_o SHALL equal latched line[64k+63:64k]; k increments on each resp_i=1.
REQ-022 Gaps are legal: resp_i=0 holds k and all state.
REQ-023 On the beat with k=BEATS-1 and resp_i=1, SHALL go to DONE; k wraps to 0.
REQ-024 DONE SHALL last exactly one cycle with resp_o=1, then IDLE; requests are ignored in DONE; the requester drops its request in the resp_o cycle.
REQ-025 Latency with resp_i=1 every cycle: request seen at edge 0, beats at cycles 1-4, resp_o at cycle 5.
REQ-026 line_o SHALL update only on read beats; write-back SHALL not modify line_o.

Reset
REQ-027 While rst=0 at an edge: state=IDLE, k=0, read_o=write_o=resp_o=0, line_o=0, address_o=0, burst_o=0, err_o=0.
REQ-028 Reset mid-burst SHALL abort with no resp_o; memory sees read_o/write_o fall the cycle after the edge.

Configuration
REQ-029 With CACHELINE_ADAPTOR_TIMEOUT_EN defined: counter counts cycles since last resp_i within a burst; reaching TIMEOUT SHALL set err_o, go to DONE (resp_o pulse, partial line_o), clear on next burst start.
REQ-030 Without CACHELINE_ADAPTOR_TIMEOUT_EN: err_o tied 0, bursts wait indefinitely, no counter logic.

Structure
REQ-031 State typedef cla_state_t and constant CLA_BEATS SHALL live in rv32i_types.
REQ-032 The timeout counter SHALL be the sub-module cla_timeout_ctr, instantiated only under the macro.
REQ-033 Beat packing and unpacking SHALL use indexed part-selects, not shift registers.

Verification
REQ-034 Read, address_i=0x0000_1234, burst_i=0x11..,0x22..,0x33..,0x44.. back-to-back -> address_o=0x0000_1220, resp_o at cycle 5, line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-035 Write, line_i=256'h0123...EF, resp_i every other cycle -> burst_o steps through line beats 0..3, resp_o one cycle after the 4th resp_i.
REQ-036 read_i=write_i=1 simultaneously -> write_o=1, read_o=0, line_o unchanged.
REQ-037 rst=0 asserted after beat 2 of a read -> next cycle read_o=0, resp_o never pulses; a new read completes correctly.
REQ-038 Macro on, TIMEOUT=8, resp_i stuck 0 after beat 1 -> err_o=1 and resp_o pulse 8 cycles after beat 1; macro off -> read_o held, err_o=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the cache-line burst adaptor.
package rv32i_types;

  localparam int CLA_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } cla_state_t;

endpackage

// File: rtl/cla_timeout_ctr.sv
// Idle-cycle counter for a memory burst; built only with CACHELINE_ADAPTOR_TIMEOUT_EN.
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
module cla_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic beat_i,
  output logic hit_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign hit_o = run_i && !beat_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || beat_i)
      cnt_d = '0;
    else if (!hit_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/cacheline_burst_adaptor.sv
// Converts cache line fill/write-back requests into BEATS-beat memory bursts.
// Optional per-beat timeout abort: CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_burst_adaptor
  import rv32i_types::*;
#(
  parameter int BEATS   = CLA_BEATS,
  parameter int BEAT_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_i,
  input  logic                    write_i,
  input  logic [31:0]             address_i,
  input  logic [BEATS*BEAT_W-1:0] line_i,
  output logic [BEATS*BEAT_W-1:0] line_o,
  output logic                    resp_o,
  output logic [31:0]             address_o,
  output logic                    read_o,
  output logic                    write_o,
  output logic [BEAT_W-1:0]       burst_o,
  input  logic [BEAT_W-1:0]       burst_i,
  input  logic                    resp_i,
  output logic                    err_o
);

  localparam int LINE_W = BEATS * BEAT_W;
  localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  cla_state_t        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [26:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] rline_q, rline_d;
  logic [BEAT_W-1:0] burst_q, burst_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              resp_q, resp_d;
  logic              err_q, err_d;
  logic              last_beat;
  logic              to_hit;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic in_burst;
  assign in_burst = (state_q == RD_BURST) || (state_q == WR_BURST);

  cla_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run_i  (in_burst),
    .beat_i (resp_i),
    .hit_o  (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif

  assign last_beat = (k_q == KW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    burst_d = burst_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (write_i || read_i) begin
          state_d = write_i ? WR_BURST : RD_BURST;
          k_d     = '0;
          addr_d  = address_i[31:5];
          wline_d = line_i;
          err_d   = 1'b0;
        end
      end
      RD_BURST, WR_BURST: begin
        if (resp_i) begin
          if (state_q == RD_BURST)
            rline_d[k_q*BEAT_W +: BEAT_W] = burst_i;
          if (last_beat) begin
            state_d = DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else if (to_hit) begin
          state_d = DONE;
          k_d     = '0;
          err_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered outputs track the state being entered.
    rd_d   = (state_d == RD_BURST);
    wr_d   = (state_d == WR_BURST);
    resp_d = (state_d == DONE);
    if (state_d == WR_BURST)
      burst_d = wline_d[k_d*BEAT_W +: BEAT_W];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      burst_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      burst_q <= burst_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  assign line_o    = rline_q;
  assign resp_o    = resp_q;
  assign address_o = {addr_q, 5'b0};
  assign read_o    = rd_q;
  assign write_o   = wr_q;
  assign burst_o   = burst_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor (TIMEOUT=8).
module tb_cacheline_burst_adaptor;

  logic         clk;
  logic         rst;
  logic         read_i;
  logic         write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;
  logic         err_o;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] B11 = {8{8'h11}};
  localparam logic [63:0] B22 = {8{8'h22}};
  localparam logic [63:0] B33 = {8{8'h33}};
  localparam logic [63:0] B44 = {8{8'h44}};
  localparam logic [255:0] RLINE = {B44, B33, B22, B11};
  localparam logic [255:0] WLINE =
    256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;

  logic [63:0] wbeat [4];
  logic [63:0] nbeat [4];

  cacheline_burst_adaptor #(
    .BEATS   (4),
    .BEAT_W  (64),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    wbeat[0] = 64'h8796a5b4c3d2e1f0;
    wbeat[1] = 64'h0f1e2d3c4b5a6978;
    wbeat[2] = 64'hfedcba9876543210;
    wbeat[3] = 64'h0123456789abcdef;
    nbeat[0] = 64'h0101010101010101;
    nbeat[1] = 64'h0202020202020202;
    nbeat[2] = 64'h0303030303030303;
    nbeat[3] = 64'h0404040404040404;

    rst = 1'b0; read_i = 1'b0; write_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0; resp_i = 1'b0;
    step(); step();
    check("rst_read_o",  read_o,    0);
    check("rst_write_o", write_o,   0);
    check("rst_resp_o",  resp_o,    0);
    check("rst_line_o",  line_o,    0);
    check("rst_addr_o",  address_o, 0);
    check("rst_burst_o", burst_o,   0);
    check("rst_err_o",   err_o,     0);

    // Back-to-back read
    rst = 1'b1;
    read_i = 1'b1; address_i = 32'h0000_1234;
    step();
    check("rd_read_o", read_o, 1);
    check("rd_addr_o", address_o, 32'h0000_1220);
    resp_i = 1'b1; burst_i = B11; step();
    check("rd_b1_resp", resp_o, 0);
    burst_i = B22; step();
    burst_i = B33; step();
    check("rd_b3_read_o", read_o, 1);
    check("rd_b3_addr", address_o, 32'h0000_1220);
    burst_i = B44; step();
    check("rd_done_resp", resp_o, 1);
    check("rd_done_read_o", read_o, 0);
    check("rd_done_line", line_o, RLINE);
    read_i = 1'b0; resp_i = 1'b0; burst_i = '0;
    step();
    check("rd_after_resp", resp_o, 0);
    check("rd_line_held", line_o, RLINE);

    // Write-back with gaps
    write_i = 1'b1; line_i = WLINE; address_i = 32'h8000_00ff;
    step();
    check("wr_write_o", write_o, 1);
    check("wr_addr_o", address_o, 32'h8000_00e0);
    check("wr_beat0", burst_o, wbeat[0]);
    for (int b = 0; b < 4; b++) begin
      resp_i = 1'b0; step();
      check($sformatf("wr_gap_beat%0d", b), burst_o, wbeat[b]);
      check($sformatf("wr_gap_wo%0d", b), write_o, 1);
      resp_i = 1'b1; step();
      if (b < 3) begin
        check($sformatf("wr_next_beat%0d", b + 1), burst_o, wbeat[b+1]);
        check($sformatf("wr_noresp%0d", b), resp_o, 0);
      end
    end
    check("wr_done_resp", resp_o, 1);
    check("wr_done_write_o", write_o, 0);
    check("wr_line_o_kept", line_o, RLINE);
    write_i = 1'b0; resp_i = 1'b0; line_i = '0;
    step();
    check("wr_after_resp", resp_o, 0);

    // Simultaneous read and write: write wins
    read_i = 1'b1; write_i = 1'b1; line_i = ~WLINE; address_i = 32'h0000_0040;
    step();
    check("both_write_o", write_o, 1);
    check("both_read_o", read_o, 0);
    resp_i = 1'b1; burst_i = 64'hdead_beef_dead_beef;
    step(); step(); step(); step();
    check("both_resp", resp_o, 1);
    check("both_line_o", line_o, RLINE);
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    step();

    // Reset mid-read
    read_i = 1'b1; address_i = 32'h0000_2000;
    step();
    resp_i = 1'b1; burst_i = {8{8'haa}}; step();
    burst_i = {8{8'hbb}}; step();
    rst = 1'b0; resp_i = 1'b0; read_i = 1'b0;
    step();
    check("mid_rst_read_o", read_o, 0);
    check("mid_rst_resp", resp_o, 0);
    check("mid_rst_line", line_o, 0);
    rst = 1'b1;
    step();
    check("mid_rst_noresp", resp_o, 0);
    read_i = 1'b1; address_i = 32'h0000_abcd;
    step();
    check("rd2_addr_o", address_o, 32'h0000_abc0);
    resp_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      burst_i = nbeat[b];
      step();
    end
    check("rd2_resp", resp_o, 1);
    check("rd2_line", line_o, {nbeat[3], nbeat[2], nbeat[1], nbeat[0]});
    read_i = 1'b0; resp_i = 1'b0;
    step();

    // Memory stalls after the first beat
    read_i = 1'b1; address_i = 32'h0000_0100;
    step();
    resp_i = 1'b1; burst_i = {8{8'h5a}};
    step();
    resp_i = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      check($sformatf("stall_noresp%0d", i), resp_o, 0);
    end
    step();
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    check("to_resp", resp_o, 1);
    check("to_err", err_o, 1);
    check("to_partial_line", line_o,
          {nbeat[3], nbeat[2], nbeat[1], {8{8'h5a}}});
    read_i = 1'b0;
    step();
    check("to_err_sticky", err_o, 1);
    read_i = 1'b1;
    step();
    check("to_err_clear", err_o, 0);
`else
    check("stall_read_o", read_o, 1);
    check("stall_err", err_o, 0);
    check("stall_resp", resp_o, 0);
    step(); step(); step();
    check("stall_read_o_late", read_o, 1);
`endif
    read_i = 1'b0; rst = 1'b0;
    step();
    check("final_read_o", read_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
